// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader : boots instruction memory from a byte stream (header, LE words,
//               XOR checksum) and releases the core reset on a good load.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [29:0] BASE_ADDR  = 30'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [29:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        done,
  output logic        error,
  output logic [15:0] loaded_words
);

  localparam logic [2:0] S_HDR0 = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [31:0] DEPTH_LIM = IMEM_DEPTH;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] wbuf;
  logic [7:0]  checksum;

  logic        xfer;
  logic [15:0] n_hdr;
  logic        last_byte;
  logic        last_word;
  logic        ready_d;
  logic        done_d;
  logic        error_d;

  assign xfer      = in_valid & in_ready;
  assign n_hdr     = {in_data, n_lo};
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = (word_idx == n_words - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_HDR0;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_HDR0: if (xfer) next_state = S_HDR1;
      S_HDR1: begin
        if (xfer) begin
          if ({16'd0, n_hdr} > DEPTH_LIM) begin
            next_state = S_ERR;
          end else if (n_hdr == 16'd0) begin
            next_state = S_CSUM;
          end else begin
            next_state = S_DATA;
          end
        end
      end
      S_DATA: if (xfer && last_byte && last_word) next_state = S_CSUM;
      S_CSUM: if (xfer) next_state = (in_data == checksum) ? S_DONE : S_ERR;
      S_DONE: next_state = S_DONE;
      S_ERR:  next_state = S_ERR;
      default: next_state = S_HDR0;
    endcase
  end

  // Status outputs are registered from the upcoming state so they change on
  // the same edge that accepts the deciding byte.
  always_comb begin
    ready_d = (next_state != S_DONE) && (next_state != S_ERR);
    done_d  = (next_state == S_DONE);
    error_d = (next_state == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 32'd0;
      core_rst_n   <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      loaded_words <= 16'd0;
      checksum     <= 8'd0;
      byte_idx     <= 2'd0;
      word_idx     <= 16'd0;
      n_lo         <= 8'd0;
      n_words      <= 16'd0;
      wbuf         <= 24'd0;
    end else begin
      in_ready   <= ready_d;
      done       <= done_d;
      error      <= error_d;
      core_rst_n <= done_d;
      imem_we    <= 1'b0;
      if (xfer) begin
        case (state)
          S_HDR0: begin
            n_lo     <= in_data;
            checksum <= checksum ^ in_data;
          end
          S_HDR1: begin
            n_words  <= n_hdr;
            checksum <= checksum ^ in_data;
          end
          S_DATA: begin
            checksum <= checksum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
              imem_we      <= 1'b1;
              imem_addr    <= BASE_ADDR + {14'd0, word_idx};
              imem_wdata   <= {in_data, wbuf};
              loaded_words <= loaded_words + 16'd1;
              word_idx     <= word_idx + 16'd1;
            end else begin
              wbuf[{byte_idx, 3'b000} +: 8] <= in_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader : randomized self-checking bench with a stream-level model.
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        imem_we;
  logic [29:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        done;
  logic        error;
  logic [15:0] loaded_words;

  always #5 clk = ~clk;

  imem_loader #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(30'd0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst_n(core_rst_n), .done(done),
    .error(error), .loaded_words(loaded_words)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed IMEM writes as {addr, data}
  logic [61:0] wq[$];
  always @(negedge clk) if (imem_we) wq.push_back({imem_addr, imem_wdata});

  logic [7:0]  stim[$];
  logic [61:0] eq[$];
  int          exp_consumed;
  bit          exp_done;
  bit          exp_err;

  // Reference: parse the stream as a whole and derive writes and outcome.
  task automatic model();
    int n;
    logic [7:0]  cs;
    logic [31:0] w;
    logic [29:0] a;
    eq.delete();
    exp_done = 0;
    exp_err  = 0;
    n = int'(stim[0]) + 256 * int'(stim[1]);
    if (n > DEPTH) begin
      exp_err = 1;
      exp_consumed = 2;
      return;
    end
    cs = stim[0] ^ stim[1];
    for (int i = 0; i < n; i++) begin
      w = {stim[5+4*i], stim[4+4*i], stim[3+4*i], stim[2+4*i]};
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      a = 30'(i);
      eq.push_back({a, w});
    end
    exp_consumed = 2 + 4 * n + 1;
    if (stim[2+4*n] == cs) exp_done = 1;
    else exp_err = 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic ignore_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_loaded", 64'(loaded_words), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ready", 64'(in_ready), 64'd1);
    wq.delete();
  endtask

  task automatic run_case(input string name, input int gapmax);
    model();
    wq.delete();
    for (int i = 0; i < stim.size(); i++) begin
      repeat ($urandom_range(0, gapmax)) begin
        @(posedge clk);
        #1;
      end
      if (i < exp_consumed) send_byte(stim[i]);
      else ignore_byte(stim[i]);
      if (i == exp_consumed - 1) begin
        check({name, ":done_edge"}, 64'(done), 64'(exp_done));
        check({name, ":error_edge"}, 64'(error), 64'(exp_err));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, ":done"}, 64'(done), 64'(exp_done));
    check({name, ":error"}, 64'(error), 64'(exp_err));
    check({name, ":core_rst_n"}, 64'(core_rst_n), 64'(exp_done));
    check({name, ":in_ready"}, 64'(in_ready), 64'd0);
    check({name, ":loaded"}, 64'(loaded_words), 64'(eq.size()));
    check({name, ":nwrites"}, 64'(wq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < wq.size(); i++)
      check({name, ":write"}, 64'(wq[i]), 64'(eq[i]));
  endtask

  task automatic load_nominal();
    stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
             8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
  endtask

  initial begin
    int n;
    logic [7:0] cs;
    logic [7:0] b;

    do_reset();

    // Nominal load with fixed expectations
    load_nominal();
    run_case("nominal", 0);
    check("nominal:w0", 64'(wq[0]), {2'b0, 30'd0, 32'h00500093});
    check("nominal:w1", 64'(wq[1]), {2'b0, 30'd1, 32'h00A00113});
    check("nominal:loaded_const", 64'(loaded_words), 64'd2);

    // Bad checksum
    do_reset();
    load_nominal();
    stim[10] = 8'h74;
    run_case("badcsum", 0);
    check("badcsum:err_const", 64'(error), 64'd1);

    // Oversize header, trailing bytes ignored
    do_reset();
    stim = '{8'h01, 8'h04, 8'h93, 8'h00, 8'h50, 8'h00};
    run_case("oversize", 0);

    // Empty load
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00};
    run_case("empty", 0);
    check("empty:done_const", 64'(done), 64'd1);

    // Throttled nominal
    do_reset();
    load_nominal();
    run_case("throttled", 5);

    // Reset mid-load after 6 bytes
    do_reset();
    load_nominal();
    wq.delete();
    for (int i = 0; i < 6; i++) send_byte(stim[i]);
    check("midrst:loaded_before", 64'(loaded_words), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst:loaded_after", 64'(loaded_words), 64'd0);
    check("midrst:in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("midrst:ready_again", 64'(in_ready), 64'd1);
    check("midrst:nwrites", 64'(wq.size()), 64'd1);
    check("midrst:w0", 64'(wq[0]), {2'b0, 30'd0, 32'h00500093});
    run_case("midrst_resend", 2);

    // Random streams, good and corrupted checksums, with trailing junk
    for (int t = 0; t < 8; t++) begin
      do_reset();
      stim.delete();
      n = $urandom_range(0, 5);
      stim.push_back(8'(n));
      stim.push_back(8'(n >> 8));
      cs = 8'(n) ^ 8'(n >> 8);
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        stim.push_back(b);
        cs = cs ^ b;
      end
      if ($urandom_range(0, 2) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      stim.push_back(cs);
      repeat ($urandom_range(0, 2)) stim.push_back(8'($urandom));
      run_case("random", 3);
    end

    // Random oversize headers
    for (int t = 0; t < 2; t++) begin
      do_reset();
      stim.delete();
      n = $urandom_range(DEPTH + 1, 65535);
      stim.push_back(8'(n));
      stim.push_back(8'(n >> 8));
      repeat (3) stim.push_back(8'($urandom));
      run_case("rand_oversize", 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 1024, meaning the number of 32-bit instruction words IMEM can accept.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning the first IMEM word address written.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the byte source presents a valid byte.
REQ-006 SHALL have port in_data, input, 8 bits: stream byte.
REQ-007 SHALL have port in_ready, output, 1 bit: loader accepts a byte; a transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-008 SHALL have port imem_we, output, 1 bit: IMEM write strobe.
REQ-009 SHALL have port imem_addr, output, 30 bits: IMEM word address, same indexing as PC[31:2].
REQ-010 SHALL have port imem_wdata, output, 32 bits: instruction word to write.
REQ-011 SHALL have port core_rst_n, output, 1 bit: active-low reset to the core; released only after a successful load.
REQ-012 SHALL have port done, output, 1 bit: load completed and checksum matched.
REQ-013 SHALL have port error, output, 1 bit: load aborted.
REQ-014 SHALL have port loaded_words, output, 16 bits: count of words written to IMEM.

Function
REQ-015 SHALL accept this stream: N_lo, N_hi (16-bit word count N), then N words of 4 bytes each, little-endian, then 1 checksum byte.
REQ-016 SHALL implement states HDR0, HDR1, DATA, CSUM, DONE, ERR; reset state is HDR0.
REQ-017 SHALL drive in_ready=1 in HDR0, HDR1, DATA and CSUM, and in_ready=0 in DONE and ERR.
REQ-018 SHALL leave state, counters and checksum unchanged when in_valid=1 and in_ready=0, and when no transfer occurs.
REQ-019 SHALL make these transitions: HDR0 -> HDR1 on transfer; HDR1 -> ERR if N>IMEM_DEPTH; otherwise HDR1 -> CSUM if N=0; otherwise HDR1 -> DATA.
REQ-020 SHALL assemble each word as byte0 -> [7:0] through byte3 -> [31:24], tracked by a 2-bit byte index that wraps 3 -> 0.
REQ-021 SHALL pulse imem_we high for exactly one cycle, in the cycle after the 4th byte of a word is transferred.
REQ-022 SHALL, during that imem_we cycle, present imem_addr = BASE_ADDR + word index (0-based) and imem_wdata = the assembled word.
REQ-023 SHALL increment loaded_words in the same edge that asserts imem_we.
REQ-024 SHALL move DATA -> CSUM on transfer of byte 3 of word N-1.
REQ-025 SHALL compute the running checksum as the XOR of every transferred byte before the checksum byte, header bytes included.
REQ-026 SHALL, in CSUM on transfer: go to DONE if the byte equals the running checksum, else go to ERR.
REQ-027 SHALL, in DONE, drive done=1 and core_rst_n=1, registered, from the edge that accepts the checksum byte.
REQ-028 SHALL, in ERR, drive error=1 and core_rst_n=0; ERR and DONE are sticky until rst_n.
REQ-029 SHALL not roll back words already written when entering ERR.
REQ-030 SHALL keep imem_we=0 in every state and cycle other than REQ-021.
REQ-031 SHALL keep imem_addr and imem_wdata stable between writes.
REQ-032 SHALL hold done=0, error=0 and core_rst_n=0 in HDR0, HDR1, DATA and CSUM.

Reset
REQ-033 SHALL, on a rising edge with rst_n=0, set: state=HDR0, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_rst_n=0, done=0, error=0, loaded_words=0, checksum=0, byte index=0, word index=0.
REQ-034 SHALL, on reset mid-operation, discard any partial word and not clear IMEM contents.
REQ-035 SHALL drive in_ready=1 from the first edge with rst_n=1.

Verification
REQ-036 SHALL pass a nominal load: bytes 02 00 93 00 50 00 13 01 A0 00 73 -> imem_we at addr 0 data 0x00500093, then addr 1 data 0x00A00113; done=1, core_rst_n=1, loaded_words=2, in_ready=0.
REQ-037 SHALL pass a bad checksum: the same stream with last byte 74 -> error=1, done=0, core_rst_n=0, two writes occurred, in_ready=0.
REQ-038 SHALL pass an oversize load: header 01 04 (N=1025, IMEM_DEPTH=1024) -> error=1 on the edge after the 2nd byte, no imem_we, following bytes ignored.
REQ-039 SHALL pass an empty load: bytes 00 00 00 -> done=1, core_rst_n=1, loaded_words=0, no imem_we.
REQ-040 SHALL pass a throttled stream: the nominal stream with in_valid deasserted 0-5 random cycles between bytes -> identical writes and final outputs as REQ-036.
REQ-041 SHALL pass reset mid-load: rst_n=0 for 1 cycle after 6 bytes of the nominal stream -> no further imem_we, loaded_words=1 before reset and 0 after, state HDR0; resending the full nominal stream then gives the REQ-036 results.
